cr_xp10_decomp_ib_tlv_parser: RTL

Ingress TLV parser for the XP10 decompressor. It accepts the inbound AXI4-stream TLV word stream and classifies each TLV by its header word. Payload words of data TLVs go to the decompressor data path. All other TLVs, plus the data-TLV header word itself, go to the passthrough path. It is the receive-side counterpart of the backend that merges decompressed data and passthrough TLVs onto the outbound stream.

---
 rtl/cr_xp10_decomp_ib_tlv_parser_if.sv | 57 +++++
 rtl/cr_xp10_decomp_ib_tlv_parser.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cr_xp10_decomp_ib_tlv_parser_if.sv
// ----------------------------------------------------------------------------
// cr_xp10_decomp_ib_tlv_parser_if
//
// Purpose: bundles the inbound TLV stream, the passthrough (PT) and
// decompressor data-path (DP) output streams, the framing-error pulse and the
// optional word counters of the XP10 decompressor ingress TLV parser.
//
// Signals:
//   ib_tvalid/ib_tdata/ib_tsot/ib_tlast  inbound word, start/end of TLV
//   ib_tready                            inbound ready (from parser)
//   pt_valid/pt_data/pt_sot/pt_eot       passthrough word and TLV framing
//   pt_is_dhdr                           PT word is a data-TLV header
//   pt_ready                             passthrough sink ready
//   dp_valid/dp_data/dp_eot              decompressor payload word
//   dp_ready                             decompressor sink ready
//   err_len                              one-cycle framing error pulse
//   stat_pt_words/stat_dp_words          handoff counters (0 when not built)
//
// Modports:
//   slave  - the parser
//   master - the environment (stream source and both sinks)
// ----------------------------------------------------------------------------
interface cr_xp10_decomp_ib_tlv_parser_if;
  logic        ib_tvalid;
  logic [63:0] ib_tdata;
  logic        ib_tsot;
  logic        ib_tlast;
  logic        ib_tready;

  logic        pt_valid;
  logic [63:0] pt_data;
  logic        pt_sot;
  logic        pt_eot;
  logic        pt_is_dhdr;
  logic        pt_ready;

  logic        dp_valid;
  logic [63:0] dp_data;
  logic        dp_eot;
  logic        dp_ready;

  logic        err_len;
  logic [31:0] stat_pt_words;
  logic [31:0] stat_dp_words;

  modport slave (
    input  ib_tvalid, ib_tdata, ib_tsot, ib_tlast, pt_ready, dp_ready,
    output ib_tready, pt_valid, pt_data, pt_sot, pt_eot, pt_is_dhdr,
           dp_valid, dp_data, dp_eot, err_len, stat_pt_words, stat_dp_words
  );

  modport master (
    output ib_tvalid, ib_tdata, ib_tsot, ib_tlast, pt_ready, dp_ready,
    input  ib_tready, pt_valid, pt_data, pt_sot, pt_eot, pt_is_dhdr,
           dp_valid, dp_data, dp_eot, err_len, stat_pt_words, stat_dp_words
  );
endinterface

// File: rtl/cr_xp10_decomp_ib_tlv_parser.sv
// ----------------------------------------------------------------------------
// cr_xp10_decomp_ib_tlv_parser
//
// Purpose: ingress TLV parser of the XP10 decompressor. Classifies each TLV
// by its header word: payload words of data TLVs go to the decompressor data
// path (DP); every other TLV, and the data-TLV header itself, goes to the
// passthrough path (PT). Length/framing violations raise a one-cycle err_len
// and the parser resynchronises on the next header.
//
// Parameters:
//   DATA_TLV_TYPE  header type routed to DP (default 8'h05)
//   LEN_W          width of the header length field and word counter
//
// Ports:
//   clk    core clock
//   rst_n  asynchronous active-low reset
//   bus    cr_xp10_decomp_ib_tlv_parser_if.slave (inbound stream, PT and DP
//          output streams, err_len, stat counters)
//
// Configuration macro:
//   CR_XP10_DECOMP_IB_STATS_EN  when defined, stat_pt_words/stat_dp_words
//   count valid&ready handoffs on each output (wrapping, cleared by reset);
//   when undefined both ports are tied to 0.
// ----------------------------------------------------------------------------
module cr_xp10_decomp_ib_tlv_parser #(
  parameter logic [7:0]  DATA_TLV_TYPE = 8'h05,
  parameter int unsigned LEN_W         = 24
) (
  input logic                           clk,
  input logic                           rst_n,
  cr_xp10_decomp_ib_tlv_parser_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_PBODY = 2'd1,
    ST_DBODY = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);

  // Registered state
  state_t           r_state;
  logic [LEN_W-1:0] r_cnt;
  logic             r_rdy_en;
  logic             r_err;
  logic             r_pt_valid;
  logic [63:0]      r_pt_data;
  logic             r_pt_sot;
  logic             r_pt_eot;
  logic             r_pt_dhdr;
  logic             r_dp_valid;
  logic [63:0]      r_dp_data;
  logic             r_dp_eot;

  // Decode of the current inbound word
  logic [LEN_W-1:0] w_hdr_len;
  logic [LEN_W-1:0] w_hdr_rem;
  logic             w_hdr_is_d;
  logic             w_hdr_eot;
  logic             w_is_hdr;
  logic             w_cnt_last;
  logic             w_body_eot;
  logic             w_tgt_pt;
  logic             w_tgt_dp;
  logic             w_ready;
  logic             w_acc;
  logic             w_pt_load;
  logic             w_dp_load;
  logic             w_err;
  state_t           w_nxt_state;
  logic [LEN_W-1:0] w_nxt_cnt;

  // Word classification, routing target, ready and next-state decode
  always_comb begin
    w_hdr_len  = bus.ib_tdata[8 +: LEN_W];
    w_hdr_is_d = (bus.ib_tdata[7:0] == DATA_TLV_TYPE);
    // A zero length field is treated as a header-only TLV.
    if (w_hdr_len == CNT_ZERO) begin
      w_hdr_rem = CNT_ZERO;
    end else begin
      w_hdr_rem = w_hdr_len - CNT_ONE;
    end
    w_hdr_eot = bus.ib_tlast || (w_hdr_rem == CNT_ZERO);

    // In DRAIN a start-of-TLV word is discarded like any other word.
    w_is_hdr   = bus.ib_tsot && (r_state != ST_DRAIN);
    w_cnt_last = (r_cnt == CNT_ONE);
    w_body_eot = bus.ib_tlast || w_cnt_last;

    w_tgt_pt = w_is_hdr || (r_state == ST_PBODY);
    w_tgt_dp = (r_state == ST_DBODY) && !bus.ib_tsot;

    if (!r_rdy_en) begin
      w_ready = 1'b0;
    end else if (w_tgt_pt) begin
      w_ready = !r_pt_valid || bus.pt_ready;
    end else if (w_tgt_dp) begin
      w_ready = !r_dp_valid || bus.dp_ready;
    end else begin
      // Words that are only discarded (DRAIN, stray word in HDR).
      w_ready = 1'b1;
    end

    w_acc     = bus.ib_tvalid && w_ready;
    w_pt_load = w_acc && w_tgt_pt;
    w_dp_load = w_acc && w_tgt_dp;

    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_err       = 1'b0;
    if (w_is_hdr) begin
      // A header inside a body closes the open TLV, which is an error in
      // itself; the header is then parsed normally.
      w_err = (r_state != ST_HDR) || (bus.ib_tlast != (w_hdr_rem == CNT_ZERO));
      if (w_hdr_eot) begin
        w_nxt_cnt   = CNT_ZERO;
        w_nxt_state = bus.ib_tlast ? ST_HDR : ST_DRAIN;
      end else begin
        w_nxt_cnt   = w_hdr_rem;
        w_nxt_state = w_hdr_is_d ? ST_DBODY : ST_PBODY;
      end
    end else begin
      case (r_state)
        ST_HDR: begin
          // Stray word where a header was expected; a stray word that
          // carries tlast already ends the bad TLV.
          w_err       = 1'b1;
          w_nxt_cnt   = CNT_ZERO;
          w_nxt_state = bus.ib_tlast ? ST_HDR : ST_DRAIN;
        end
        ST_PBODY, ST_DBODY: begin
          w_err = (bus.ib_tlast != w_cnt_last);
          if (w_body_eot) begin
            w_nxt_cnt   = CNT_ZERO;
            w_nxt_state = bus.ib_tlast ? ST_HDR : ST_DRAIN;
          end else begin
            w_nxt_cnt   = r_cnt - CNT_ONE;
            w_nxt_state = r_state;
          end
        end
        ST_DRAIN: begin
          w_nxt_cnt   = CNT_ZERO;
          w_nxt_state = bus.ib_tlast ? ST_HDR : ST_DRAIN;
        end
        default: begin
          w_nxt_cnt   = CNT_ZERO;
          w_nxt_state = ST_HDR;
        end
      endcase
    end
  end

  // Parser FSM, word counter and both single-entry output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_HDR;
      r_cnt      <= CNT_ZERO;
      r_rdy_en   <= 1'b0;
      r_err      <= 1'b0;
      r_pt_valid <= 1'b0;
      r_pt_data  <= 64'd0;
      r_pt_sot   <= 1'b0;
      r_pt_eot   <= 1'b0;
      r_pt_dhdr  <= 1'b0;
      r_dp_valid <= 1'b0;
      r_dp_data  <= 64'd0;
      r_dp_eot   <= 1'b0;
    end else begin
      // Holds ib_tready low until the first cycle after reset release.
      r_rdy_en <= 1'b1;
      r_err    <= w_acc && w_err;
      if (w_acc) begin
        r_state <= w_nxt_state;
        r_cnt   <= w_nxt_cnt;
      end

      if (w_pt_load) begin
        r_pt_valid <= 1'b1;
        r_pt_data  <= bus.ib_tdata;
        r_pt_sot   <= w_is_hdr;
        r_pt_eot   <= w_is_hdr ? w_hdr_eot : w_body_eot;
        r_pt_dhdr  <= w_is_hdr && w_hdr_is_d;
      end else if (bus.pt_ready) begin
        r_pt_valid <= 1'b0;
      end

      if (w_dp_load) begin
        r_dp_valid <= 1'b1;
        r_dp_data  <= bus.ib_tdata;
        r_dp_eot   <= w_body_eot;
      end else if (bus.dp_ready) begin
        r_dp_valid <= 1'b0;
      end
    end
  end

  assign bus.ib_tready  = w_ready;
  assign bus.pt_valid   = r_pt_valid;
  assign bus.pt_data    = r_pt_data;
  assign bus.pt_sot     = r_pt_sot;
  assign bus.pt_eot     = r_pt_eot;
  assign bus.pt_is_dhdr = r_pt_dhdr;
  assign bus.dp_valid   = r_dp_valid;
  assign bus.dp_data    = r_dp_data;
  assign bus.dp_eot     = r_dp_eot;
  assign bus.err_len    = r_err;

`ifdef CR_XP10_DECOMP_IB_STATS_EN
  logic [31:0] r_stat_pt;
  logic [31:0] r_stat_dp;

  // Handoff counters, free-running and wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_pt <= 32'd0;
      r_stat_dp <= 32'd0;
    end else begin
      if (r_pt_valid && bus.pt_ready) begin
        r_stat_pt <= r_stat_pt + 32'd1;
      end
      if (r_dp_valid && bus.dp_ready) begin
        r_stat_dp <= r_stat_dp + 32'd1;
      end
    end
  end

  assign bus.stat_pt_words = r_stat_pt;
  assign bus.stat_dp_words = r_stat_dp;
`else
  assign bus.stat_pt_words = 32'd0;
  assign bus.stat_dp_words = 32'd0;
`endif

endmodule
